// File: rtl/arm_one_nios_key_pio_if.sv
// Purpose: Avalon-MM slave register bus used by the key/switch input PIO.
// Ports:   master drives address/chipselect/write_n/writedata and samples readdata;
//          slave (the PIO) samples the strobes and returns registered readdata.
interface arm_one_nios_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/arm_one_nios_key_pio.sv
// Purpose: Avalon-MM input PIO; synchronises and debounces in_port, latches edges, raises a level irq.
// Latency: readdata 1 clk after address; irq 1 clk after capture or mask change; zero-wait-state writes.
// Ports:   clk, reset_n (async active-low), bus (slave modport), in_port[WIDTH], irq. Never stalls the bus.
module arm_one_nios_key_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    arm_one_nios_key_pio_if.slave   bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    localparam int             PW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0]  PS_MAX = PW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [PW-1:0]    prescaler;
    logic             armed;

    logic             tick;
    logic             wr_en;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;

    // Only writedata[WIDTH-1:0] carries register content.
    logic unused_wdat;
    assign unused_wdat = ^bus.writedata;

    // A divider of 0 or 1 degenerates to sampling every clock.
    assign tick  = (DEBOUNCE_CYCLES <= 1) ? 1'b1 : (prescaler == PS_MAX);
    assign wr_en = bus.chipselect && !bus.write_n;

    // Edge compares the last two debounced samples; only meaningful on a tick once armed.
    always_comb begin
        edge_hit = '0;
        if (tick && armed) begin
            if (EDGE_TYPE == 0)
                edge_hit = ~prev & stable;
            else if (EDGE_TYPE == 1)
                edge_hit = prev & ~stable;
            else
                edge_hit = prev ^ stable;
        end
    end

    always_comb begin
        clr = '0;
        if (wr_en && bus.address == 2'd3)
            clr = bus.writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta    <= '0;
            sync         <= '0;
            stable       <= '0;
            prev         <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            prescaler    <= '0;
            armed        <= 1'b0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;

            if (DEBOUNCE_CYCLES <= 1 || prescaler == PS_MAX)
                prescaler <= '0;
            else
                prescaler <= prescaler + PW'(1);

            if (tick) begin
                stable <= sync;
                // First tick after reset loads prev from the live input so that
                // inputs already asserted at release do not look like an edge.
                if (!armed) begin
                    prev  <= sync;
                    armed <= 1'b1;
                end else begin
                    prev  <= stable;
                end
            end

            if (wr_en && bus.address == 2'd2)
                irqmask <= bus.writedata[WIDTH-1:0];

            // A fresh edge beats a simultaneous W1C of the same bit.
            edgecapture  <= (edgecapture & ~clr) | edge_hit;
            irq          <= |(edgecapture & irqmask);
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_arm_one_nios_key_pio.sv
module tb_arm_one_nios_key_pio;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    arm_one_nios_key_pio_if bus ();

    arm_one_nios_key_pio #(
        .WIDTH           (WIDTH),
        .EDGE_TYPE       (0),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Scoreboard queues, one entry per issued read.
    string       name_q[$];
    logic [31:0] exp_dat_q[$];
    bit          chk_irq_q[$];
    logic        exp_irq_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    logic rd_req = 1'b0;
    logic rd_d;

    // cyc = number of posedges since reset release; the DUT ticks on posedges with cyc % 4 == 0.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc  <= 0;
            rd_d <= 1'b0;
        end else begin
            cyc  <= cyc + 1;
            rd_d <= rd_req;
        end
    end

    // Monitor: a read issued before a posedge presents readdata after it.
    always @(negedge clk) begin : monitor
        string       nm;
        logic [31:0] ed;
        bit          ci;
        logic        ei;
        if (rd_d) begin
            if (exp_dat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read readdata=0x%08h with no expectation queued", bus.readdata);
            end else begin
                nm = name_q.pop_front();
                ed = exp_dat_q.pop_front();
                ci = chk_irq_q.pop_front();
                ei = exp_irq_q.pop_front();
                checks++;
                if (bus.readdata !== ed) begin
                    errors++;
                    $display("FAIL %s readdata got 0x%08h expected 0x%08h", nm, bus.readdata, ed);
                end
                if (ci) begin
                    checks++;
                    if (irq !== ei) begin
                        errors++;
                        $display("FAIL %s irq got %b expected %b", nm, irq, ei);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        int guard;
        guard = 0;
        while ((cyc % 4) != p && guard < 8) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] ed,
                      input bit ci, input logic ei);
        name_q.push_back(nm);
        exp_dat_q.push_back(ed);
        chk_irq_q.push_back(ci);
        exp_irq_q.push_back(ei);
        bus.address    = a;
        bus.chipselect = 1'b1;
        rd_req         = 1'b1;
        @(negedge clk);
        rd_req         = 1'b0;
        bus.chipselect = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        int t;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // 1. reset values
        idle(3);
        reset_n = 1'b1;
        rd("t1_data",    2'd0, 32'h0, 1'b1, 1'b0);
        rd("t1_rsvd",    2'd1, 32'h0, 1'b1, 1'b0);
        rd("t1_irqmask", 2'd2, 32'h0, 1'b1, 1'b0);
        rd("t1_edgecap", 2'd3, 32'h0, 1'b1, 1'b0);

        // 2. 2-clk glitch placed so its synchronised copy straddles no tick
        idle(8);
        wait_phase(2);
        in_port = 4'h1;
        idle(2);
        in_port = 4'h0;
        idle(12);
        rd("t2_glitch_data",    2'd0, 32'h0, 1'b1, 1'b0);
        rd("t2_glitch_edgecap", 2'd3, 32'h0, 1'b1, 1'b0);
        in_port = 4'h1;
        idle(12);
        rd("t2_held_data", 2'd0, 32'h1, 1'b1, 1'b0);
        rd("t2_held_cap",  2'd3, 32'h1, 1'b1, 1'b0);
        wr(2'd3, 32'h1);
        rd("t2_cap_clr", 2'd3, 32'h0, 1'b1, 1'b0);
        in_port = 4'h0;
        idle(12);
        rd("t2_fall_ignored", 2'd3, 32'h0, 1'b1, 1'b0);

        // 3. masked rising edge raises irq, W1C drops it
        wr(2'd2, 32'h1);
        rd("t3_irqmask", 2'd2, 32'h1, 1'b1, 1'b0);
        in_port = 4'h1;
        idle(12);
        rd("t3_edge_irq", 2'd3, 32'h1, 1'b1, 1'b1);
        wr(2'd3, 32'h1);
        idle(2);
        rd("t3_w1c_irq", 2'd3, 32'h0, 1'b1, 1'b0);

        // 4. W1C landing in the same clk as a new capture
        in_port = 4'h0;
        idle(12);
        rd("t4_pre", 2'd3, 32'h0, 1'b1, 1'b0);
        wait_phase(0);
        in_port = 4'h1;
        idle(7);
        wr(2'd3, 32'h1);
        rd("t4_race_edge_wins", 2'd3, 32'h1, 1'b1, 1'b1);
        wr(2'd3, 32'h1);
        idle(2);
        rd("t4_cleared", 2'd3, 32'h0, 1'b1, 1'b0);

        // 5. inputs asserted through reset release must not capture
        idle(2);
        in_port = 4'hF;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        rd("t5_rst_cap", 2'd3, 32'h0, 1'b1, 1'b0);
        wr(2'd2, 32'hF);
        idle(16);
        rd("t5_data",    2'd0, 32'hF, 1'b1, 1'b0);
        rd("t5_edgecap", 2'd3, 32'h0, 1'b1, 1'b0);
        rd("t5_irqmask", 2'd2, 32'hF, 1'b1, 1'b0);

        // 6. unmasked edge on bit2, ignored writes, mask-to-irq latency
        wr(2'd2, 32'h0);
        in_port = 4'hB;
        idle(12);
        rd("t6_fall_bit2", 2'd3, 32'h0, 1'b1, 1'b0);
        in_port = 4'hF;
        idle(12);
        rd("t6_rise_bit2", 2'd3, 32'h4, 1'b1, 1'b0);
        wr(2'd0, 32'hF);
        wr(2'd0, 32'h0);
        rd("t6_data_ro", 2'd0, 32'hF, 1'b1, 1'b0);
        wr(2'd1, 32'hF);
        rd("t6_rsvd", 2'd1, 32'h0, 1'b1, 1'b0);
        rd("t6_mask_untouched", 2'd2, 32'h0, 1'b1, 1'b0);
        wr(2'd3, 32'h0);
        rd("t6_w0_no_effect", 2'd3, 32'h4, 1'b1, 1'b0);
        wr(2'd2, 32'h4);
        rd("t6_mask_irq_1clk", 2'd3, 32'h4, 1'b1, 1'b1);

        // drain scoreboard
        t = 0;
        while (exp_dat_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (exp_dat_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_dat_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
